// File: rtl/sdr_frame_sequencer_pkg.sv
// Shared types and constants for the SDR frame sequencer: FSM state encoding,
// frame lengths with and without the parity T-bit, and the idle SDO level.
package sdr_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PAR   = 3'd3,
        ST_FEND  = 3'd4,
        ST_DONE  = 3'd5
    } fseq_state_e;

    localparam int unsigned FRM_BITS_NOPAR = 8;
    localparam int unsigned FRM_BITS_PAR   = 9;
    localparam logic        SDO_IDLE       = 1'b1;

endpackage

// File: rtl/sdr_frame_sequencer_bit_shifter.sv
// Serialiser for one frame: holds the payload byte, the current bit index and
// the odd-parity T-bit, and registers the SDO level driven onto the pin.
module fseq_bit_shifter
    import sdr_frame_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRM_BITS_NOPAR
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       adv_i,
    input  logic [7:0] data_i,
    output logic       sdo_o,
    output logic       last_bit_o
);

    localparam bit         HAS_PAR   = (FRAME_BITS == FRM_BITS_PAR);
    localparam logic [2:0] IDX_FIRST = 3'(FRM_BITS_NOPAR - 1);

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       sdo_q, sdo_d;
    logic       par_q, par_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        sdo_d   = sdo_q;
        par_d   = par_q;
        if (clr_i) begin
            shreg_d = '0;
            idx_d   = '0;
            sdo_d   = SDO_IDLE;
            par_d   = 1'b0;
        end else if (load_i) begin
            shreg_d = data_i;
            idx_d   = IDX_FIRST;
            sdo_d   = data_i[7];
            par_d   = ~^data_i;
        end else if (adv_i) begin
            if (idx_q != '0) begin
                shreg_d = {shreg_q[6:0], 1'b0};
                idx_d   = idx_q - 1'b1;
                sdo_d   = shreg_q[6];
            end else begin
                // Past bit 0 the only remaining symbol is the T-bit, if any.
                sdo_d = HAS_PAR ? par_q : SDO_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            idx_q   <= '0;
            sdo_q   <= SDO_IDLE;
            par_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            sdo_q   <= sdo_d;
            par_q   <= par_d;
        end
    end

    assign sdo_o      = sdo_q;
    assign last_bit_o = (idx_q == '0);

endmodule

// File: rtl/sdr_frame_sequencer.sv
// Frame sequencer FSM: fetches bytes from the TX buffer and serialises them MSB
// first on bit ticks. Define FSEQ_PARITY_EN to append an odd-parity T-bit.
module sdr_frame_sequencer
    import sdr_frame_sequencer_pkg::*;
#(
    parameter int unsigned FRM_W = 8
) (
    input  logic             i_fseq_clk,
    input  logic             i_fseq_rst,
    input  logic             i_fseq_start,
    input  logic [FRM_W-1:0] i_fseq_no_frms,
    input  logic             i_fseq_abort,
    input  logic             i_fseq_bit_tick,
    input  logic [7:0]       i_fseq_data,
    input  logic             i_fseq_data_vld,
    output logic             o_fseq_data_req,
    output logic             o_fseq_sdo,
    output logic             o_fseq_sdo_en,
    output logic [FRM_W-1:0] o_fseq_frm_cnt,
    output logic             o_fseq_last_frame,
    output logic             o_fseq_busy,
    output logic             o_fseq_done
);

`ifdef FSEQ_PARITY_EN
    localparam int unsigned FRAME_BITS = FRM_BITS_PAR;
`else
    localparam int unsigned FRAME_BITS = FRM_BITS_NOPAR;
`endif

    fseq_state_e      state_q, state_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [FRM_W-1:0] nfrm_q, nfrm_d;
    logic [FRM_W-1:0] frm_inc;
    logic             req_q, req_d;
    logic             en_q, en_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sh_clr, sh_load, sh_adv, sh_last_bit;

    assign frm_inc = frm_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        nfrm_d    = nfrm_q;
        req_d     = req_q;
        en_d      = en_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sh_clr    = 1'b0;
        sh_load   = 1'b0;
        sh_adv    = 1'b0;
        // Abort outranks every per-state action, including tick and data_vld.
        if (state_q != ST_IDLE && i_fseq_abort) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            en_d    = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            sh_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_fseq_start) begin
                        if (i_fseq_no_frms != '0) begin
                            state_d   = ST_FETCH;
                            nfrm_d    = i_fseq_no_frms;
                            frm_cnt_d = '0;
                            req_d     = 1'b1;
                            busy_d    = 1'b1;
                            last_d    = (i_fseq_no_frms == FRM_W'(1));
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_fseq_data_vld) begin
                        sh_load = 1'b1;
                        req_d   = 1'b0;
                        en_d    = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (i_fseq_bit_tick) begin
                        if (sh_last_bit) begin
`ifdef FSEQ_PARITY_EN
                            sh_adv  = 1'b1;
                            state_d = ST_PAR;
`else
                            sh_clr  = 1'b1;
                            en_d    = 1'b0;
                            state_d = ST_FEND;
`endif
                        end else begin
                            sh_adv = 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (i_fseq_bit_tick) begin
                        sh_clr  = 1'b1;
                        en_d    = 1'b0;
                        state_d = ST_FEND;
                    end
                end
                ST_FEND: begin
                    frm_cnt_d = frm_inc;
                    if (frm_inc == nfrm_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        last_d  = (frm_inc == nfrm_q - 1'b1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_fseq_clk) begin
        if (i_fseq_rst) begin
            state_q   <= ST_IDLE;
            frm_cnt_q <= '0;
            nfrm_q    <= '0;
            req_q     <= 1'b0;
            en_q      <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
            nfrm_q    <= nfrm_d;
            req_q     <= req_d;
            en_q      <= en_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    fseq_bit_shifter #(
        .FRAME_BITS (FRAME_BITS)
    ) u_shifter (
        .clk_i      (i_fseq_clk),
        .rst_i      (i_fseq_rst),
        .clr_i      (sh_clr),
        .load_i     (sh_load),
        .adv_i      (sh_adv),
        .data_i     (i_fseq_data),
        .sdo_o      (o_fseq_sdo),
        .last_bit_o (sh_last_bit)
    );

    assign o_fseq_data_req   = req_q;
    assign o_fseq_sdo_en     = en_q;
    assign o_fseq_frm_cnt    = frm_cnt_q;
    assign o_fseq_last_frame = last_q;
    assign o_fseq_busy       = busy_q;
    assign o_fseq_done       = done_q;

endmodule

// File: tb/tb_sdr_frame_sequencer.sv
// Directed bench for sdr_frame_sequencer: a per-cycle vector table for reset,
// zero-frame start and abort/reset collisions, plus full multi-frame transfers.
module tb_sdr_frame_sequencer;

`ifdef FSEQ_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst, start, abort, tick, vld;
    logic [7:0] nfrm, data;
    logic       req, sdo, sdo_en, last, busy, done;
    logic [7:0] cnt;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    typedef struct {
        logic       rst, start, abort, tick, vld;
        logic [7:0] nfrm, data;
        logic       e_busy, e_done, e_req, e_sdo, e_en, e_last;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t v[15];

    sdr_frame_sequencer #(.FRM_W(8)) dut (
        .i_fseq_clk        (clk),
        .i_fseq_rst        (rst),
        .i_fseq_start      (start),
        .i_fseq_no_frms    (nfrm),
        .i_fseq_abort      (abort),
        .i_fseq_bit_tick   (tick),
        .i_fseq_data       (data),
        .i_fseq_data_vld   (vld),
        .o_fseq_data_req   (req),
        .o_fseq_sdo        (sdo),
        .o_fseq_sdo_en     (sdo_en),
        .o_fseq_frm_cnt    (cnt),
        .o_fseq_last_frame (last),
        .o_fseq_busy       (busy),
        .o_fseq_done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; vld = 1'b0;
        nfrm = 8'd0; data = 8'd0;
    endtask

    // Entry: FETCH for this frame has just been entered. Exit: in FEND.
    task automatic run_frame(input logic [7:0] b, input logic exp_last,
                             input logic [7:0] cnt_before, input int stall);
        logic eb;
        chk1($sformatf("fr%0h req", b), req, 1'b1);
        chk1($sformatf("fr%0h last", b), last, exp_last);
        chk8($sformatf("fr%0h cnt", b), cnt, cnt_before);
        for (int s = 0; s < stall; s++) begin
            tick = (s % 2 == 0);
            cyc();
            chk1($sformatf("stall%0d req", s), req, 1'b1);
            chk1($sformatf("stall%0d en", s), sdo_en, 1'b0);
            chk1($sformatf("stall%0d sdo", s), sdo, 1'b1);
        end
        tick = 1'b0;
        data = b; vld = 1'b1;
        cyc();
        vld = 1'b0;
        chk1($sformatf("fr%0h req drop", b), req, 1'b0);
        for (int k = 0; k < NB; k++) begin
            if (k < 8) eb = b[7-k];
            else       eb = ~^b;
            for (int j = 0; j < 4; j++) begin
                chk1($sformatf("fr%0h bit%0d c%0d sdo", b, k, j), sdo, eb);
                chk1($sformatf("fr%0h bit%0d c%0d en", b, k, j), sdo_en, 1'b1);
                tick = (j == 3);
                cyc();
                tick = 1'b0;
            end
        end
        chk1($sformatf("fr%0h fend en", b), sdo_en, 1'b0);
        chk1($sformatf("fr%0h fend busy", b), busy, 1'b1);
        chk1($sformatf("fr%0h fend last", b), last, exp_last);
        chk8($sformatf("fr%0h fend cnt", b), cnt, cnt_before);
    endtask

    initial begin
        logic [7:0] b;
        //        rst   start abort tick  vld   nfrm   data    busy  done  req   sdo   en    last  cnt
        v[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        v[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        v[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
        v[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        v[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        v[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        v[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
        v[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        idle_in();
        rst = 1'b1;
        cyc();

        for (int i = 0; i < 15; i++) begin
            rst = v[i].rst; start = v[i].start; abort = v[i].abort;
            tick = v[i].tick; vld = v[i].vld; nfrm = v[i].nfrm; data = v[i].data;
            cyc();
            chk1($sformatf("row%0d busy", i), busy, v[i].e_busy);
            chk1($sformatf("row%0d done", i), done, v[i].e_done);
            chk1($sformatf("row%0d req", i), req, v[i].e_req);
            chk1($sformatf("row%0d sdo", i), sdo, v[i].e_sdo);
            chk1($sformatf("row%0d sdo_en", i), sdo_en, v[i].e_en);
            chk1($sformatf("row%0d last", i), last, v[i].e_last);
            chk8($sformatf("row%0d cnt", i), cnt, v[i].e_cnt);
        end
        idle_in();

        // Single frame right after the mid-shift reset
        n_done = 0;
        nfrm = 8'd1; start = 1'b1; cyc(); start = 1'b0;
        run_frame(8'hC3, 1'b1, 8'd0, 0);
        cyc();
        chk1("one done", done, 1'b1);
        chk8("one cnt", cnt, 8'd1);
        chk1("one done last", last, 1'b0);
        cyc();
        chk1("one idle busy", busy, 1'b0);
        chk8("one ndone", 8'(n_done), 8'd1);

        // Three frames A5/3C/FF
        n_done = 0;
        nfrm = 8'd3; start = 1'b1; cyc(); start = 1'b0;
        run_frame(8'hA5, 1'b0, 8'd0, 0);
        cyc();
        run_frame(8'h3C, 1'b0, 8'd1, 0);
        cyc();
        run_frame(8'hFF, 1'b1, 8'd2, 0);
        cyc();
        chk1("x3 done", done, 1'b1);
        chk1("x3 done busy", busy, 1'b1);
        chk8("x3 cnt", cnt, 8'd3);
        cyc();
        chk1("x3 idle busy", busy, 1'b0);
        chk1("x3 idle done", done, 1'b0);
        chk1("x3 idle sdo", sdo, 1'b1);
        chk8("x3 ndone", 8'(n_done), 8'd1);

        // Data withheld 20 cycles in FETCH
        n_done = 0;
        nfrm = 8'd2; start = 1'b1; cyc(); start = 1'b0;
        run_frame(8'h81, 1'b0, 8'd0, 20);
        cyc();
        run_frame(8'h7E, 1'b1, 8'd1, 0);
        cyc();
        chk8("stall cnt", cnt, 8'd2);
        cyc();
        chk8("stall ndone", 8'(n_done), 8'd1);

        // Abort at bit 4 of frame 2 of 5
        n_done = 0;
        nfrm = 8'd5; start = 1'b1; cyc(); start = 1'b0;
        run_frame(8'h96, 1'b0, 8'd0, 0);
        cyc();
        chk8("ab cnt fetch", cnt, 8'd1);
        b = 8'h5A;
        data = b; vld = 1'b1; cyc(); vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("ab bit%0d", k), sdo, b[7-k]);
            repeat (3) cyc();
            tick = 1'b1; cyc(); tick = 1'b0;
        end
        chk1("ab bit4", sdo, b[4]);
        abort = 1'b1; tick = 1'b1; cyc(); abort = 1'b0; tick = 1'b0;
        chk1("ab busy", busy, 1'b0);
        chk1("ab en", sdo_en, 1'b0);
        chk1("ab req", req, 1'b0);
        chk1("ab last", last, 1'b0);
        chk1("ab sdo", sdo, 1'b1);
        chk8("ab cnt", cnt, 8'd1);
        repeat (3) cyc();
        chk1("ab stays idle", busy, 1'b0);
        chk8("ab ndone", 8'(n_done), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_frame_sequencer.md
SDR_FRAME_SEQUENCER -- requirements
Module: sdr_frame_sequencer

Interface
REQ-001 Parameter: FRM_W, default 8, width of frame-count input and counter.
REQ-002 i_fseq_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_fseq_rst  in  1  reset, synchronous, active-high.
REQ-004 i_fseq_start  in  1  one-cycle request to begin a transfer.
REQ-005 i_fseq_no_frms  in  FRM_W  number of frames to send; sampled only on an accepted start.
REQ-006 i_fseq_abort  in  1  terminate the transfer in progress.
REQ-007 i_fseq_bit_tick  in  1  one-cycle SCL-rate strobe; advances one serial bit.
REQ-008 i_fseq_data  in  8  frame payload byte from the TX buffer.
REQ-009 i_fseq_data_vld  in  1  i_fseq_data is valid.
REQ-010 o_fseq_data_req  out  1  byte request to the TX buffer.
REQ-011 o_fseq_sdo  out  1  serial data bit, MSB first.
REQ-012 o_fseq_sdo_en  out  1  serial output driving.
REQ-013 o_fseq_frm_cnt  out  FRM_W  frames completed in the current or last transfer.
REQ-014 o_fseq_last_frame  out  1  the frame being sent is the final one.
REQ-015 o_fseq_busy  out  1  FSM not in IDLE.
REQ-016 o_fseq_done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, SHIFT, PAR, FEND and DONE; all outputs SHALL be registered.
REQ-018 In IDLE, a start with no_frms!=0 SHALL latch no_frms, clear frm_cnt and enter FETCH next cycle; busy SHALL rise in that same cycle.
REQ-019 In IDLE, a start with no_frms==0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-020 A start while busy SHALL be ignored.
REQ-021 In FETCH, data_req SHALL be 1 until data_vld is sampled high; on that cycle the byte SHALL load the shift register, the bit index SHALL be set to 7, and the FSM SHALL enter SHIFT with data_req 0 next cycle.
REQ-022 In SHIFT and PAR, sdo_en SHALL be 1 and sdo SHALL present the current bit; each bit_tick SHALL advance exactly one bit, and bits SHALL hold between ticks.
REQ-023 After the tick for bit 0, the FSM SHALL enter PAR if FSEQ_PARITY_EN is defined and FEND otherwise; the tick in PAR SHALL enter FEND.
REQ-024 FEND SHALL last exactly one cycle and increment frm_cnt; if the new value equals the latched no_frms the FSM SHALL enter DONE, otherwise FETCH.
REQ-025 last_frame SHALL be 1 from FETCH through FEND of the frame with index no_frms-1, and 0 otherwise.
REQ-026 DONE SHALL last one cycle, pulse done, deassert sdo_en and busy on exit, and return to IDLE.
REQ-027 Abort in any non-IDLE state SHALL have priority over tick and data_vld in the same cycle, force IDLE next cycle, clear data_req, sdo_en and last_frame, hold frm_cnt, and produce no done pulse.
REQ-028 frm_cnt SHALL never wrap, since no_frms at most 2^FRM_W-1 bounds it.

Reset
REQ-029 On i_fseq_rst=1 at a clock edge: state IDLE; frm_cnt 0; sdo 1; sdo_en, data_req, last_frame, busy and done 0; shift register and latched count 0.
REQ-030 Reset SHALL take priority over start, abort and tick, including mid-transfer.

Configuration
REQ-031 Macro FSEQ_PARITY_EN: when defined, each frame SHALL be 9 bits and PAR SHALL drive the T-bit as odd parity of the byte (~^byte); when undefined, frames SHALL be 8 bits and PAR SHALL be unreachable and optimised out.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, frame-bit-count constants (8 and 9) and the idle SDO level (1).
REQ-033 A single sub-module, fseq_bit_shifter, SHALL own the shift register, bit index and parity generation; the FSM SHALL remain in the top module.

Verification
REQ-034 Start, no_frms=3, bytes A5/3C/FF, vld one cycle after each req, tick every 4 cycles -> serial 10100101 00111100 11111111 (with parity: T-bits 1,1,1); frm_cnt 1,2,3; one done pulse.
REQ-035 Start, no_frms=0 -> done pulse the next cycle; busy, data_req and sdo_en stay 0.
REQ-036 Abort during bit 4 of frame 2 of 5 -> IDLE next cycle; frm_cnt=1; no done pulse; sdo_en 0.
REQ-037 data_vld withheld 20 cycles in FETCH -> data_req held high, sdo_en 0 and no bit advance; transfer resumes normally.
REQ-038 Reset asserted mid-SHIFT simultaneous with a tick -> all outputs at reset values next cycle; a subsequent start with no_frms=1 completes cleanly.
REQ-039 Start while busy, plus abort and tick in the same cycle -> the start is ignored and the abort wins.
